// File: rtl/shift_reg_bank.sv
// DEPTH-stage by WIDTH-bit register bank with shift-up/down, parallel load,
// per-stage valid tracking and a registered occupancy count.
module shift_reg_bank #(
    parameter int                 WIDTH   = 8,
    parameter int                 DEPTH   = 4,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     En,
    input  logic                     Clr,
    input  logic [1:0]               Mode,
    input  logic [WIDTH-1:0]         D,
    input  logic                     Valid_in,
    input  logic [DEPTH*WIDTH-1:0]   P_in,
    output logic [DEPTH*WIDTH-1:0]   Q_par,
    output logic [WIDTH-1:0]         Q_hi,
    output logic [WIDTH-1:0]         Q_lo,
    output logic [DEPTH-1:0]         V_par,
    output logic [$clog2(DEPTH+1)-1:0] Count,
    output logic                     Full,
    output logic                     Empty
);

    localparam int              CW         = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_UP    = 2'b01,
        MODE_DOWN  = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_t;

    logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;
    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [CW-1:0]               count_q, count_d;

    always_comb begin
        stage_d = stage_q;
        valid_d = valid_q;
        if (Clr) begin
            stage_d = {DEPTH{RST_VAL}};
            valid_d = '0;
        end else if (En) begin
            case (mode_t'(Mode))
                MODE_UP: begin
                    stage_d = {stage_q[DEPTH-2:0], D};
                    valid_d = {valid_q[DEPTH-2:0], Valid_in};
                end
                MODE_DOWN: begin
                    stage_d = {D, stage_q[DEPTH-1:1]};
                    valid_d = {Valid_in, valid_q[DEPTH-1:1]};
                end
                MODE_LOAD: begin
                    stage_d = P_in;
                    valid_d = '1;
                end
                default: begin
                    stage_d = stage_q;
                    valid_d = valid_q;
                end
            endcase
        end
    end

    // Count tracks the next-state valid bits so it is never a cycle stale.
    always_comb begin
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + CW'(valid_d[i]);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stage_q <= {DEPTH{RST_VAL}};
            valid_q <= '0;
            count_q <= '0;
        end else begin
            stage_q <= stage_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign Q_par = stage_q;
    assign Q_hi  = stage_q[DEPTH-1];
    assign Q_lo  = stage_q[0];
    assign V_par = valid_q;
    assign Count = count_q;
    assign Full  = (count_q == FULL_COUNT);
    assign Empty = (count_q == '0);

endmodule
